// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Execute-stage ALU. Accepts an operation through a valid/ready
//             handshake and returns a registered result with zero/carry/
//             overflow/sign flags. Non-shift ops finish in one cycle; shifts
//             run on an iterative one-bit-per-cycle shifter.
//  Ports    : clk, rst (async, active-high), flush (sync discard)
//             in_valid / in_ready  : request handshake
//             alu_sel, a, b        : operation select and operands
//             out_valid / out_ready: result handshake
//             result, zf, cf, vf, sf : registered result and flags
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             cf,
  output logic             vf,
  output logic             sf
);

  localparam int SHW = $clog2(WIDTH);

  // Operation encodings; must track the ALU control decoder's ALU_* values.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] shreg_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic             zf_q, cf_q, vf_q, sf_q;

  // Single-cycle datapath, evaluated on the incoming request.
  logic             is_sub;
  logic             is_shift;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             add_cf, add_vf;
  logic             arith;
  logic [WIDTH-1:0] result_d;
  logic             zf_d, cf_d, vf_d, sf_d;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    is_sub   = (alu_sel == ALU_SUB) || (alu_sel == ALU_SLT) || (alu_sel == ALU_SLTU);
    is_shift = (alu_sel == ALU_SLL) || (alu_sel == ALU_SRL) || (alu_sel == ALU_SRA);
    shamt    = b[SHW-1:0];
    // Subtraction as a + ~b + 1 so carry-out means "no borrow".
    b_op     = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    add_cf   = sum[WIDTH];
    add_vf   = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    arith    = 1'b0;
    result_d = b;
    case (alu_sel)
      ALU_ADD, ALU_SUB: begin
        result_d = sum[WIDTH-1:0];
        arith    = 1'b1;
      end
      ALU_SLT: begin
        result_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_vf};
        arith    = 1'b1;
      end
      ALU_SLTU: begin
        result_d = {{(WIDTH-1){1'b0}}, ~add_cf};
        arith    = 1'b1;
      end
      ALU_AND:  result_d = a & b;
      ALU_OR:   result_d = a | b;
      ALU_XOR:  result_d = a ^ b;
      // Reached only with a zero shift amount: the operand passes through.
      ALU_SLL, ALU_SRL, ALU_SRA: result_d = a;
      ALU_PASS: result_d = b;
      default:  result_d = b;
    endcase

    // Compare ops report flags of the underlying subtraction, not the 0/1 result.
    if (arith) begin
      cf_d = add_cf;
      vf_d = add_vf;
      zf_d = (sum[WIDTH-1:0] == '0);
      sf_d = sum[WIDTH-1];
    end else begin
      cf_d = 1'b0;
      vf_d = 1'b0;
      zf_d = (result_d == '0);
      sf_d = result_d[WIDTH-1];
    end
  end

  // One step of the iterative shifter. The shift register's MSB still holds
  // the original a[WIDTH-1] during SRA, so it serves as the sign fill.
  always_comb begin
    case (op_q)
      ALU_SLL: shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      ALU_SRL: shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      default: shreg_d = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 4'd0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
      vf_q        <= 1'b0;
      sf_q        <= 1'b0;
    end else if (flush) begin
      // Result register deliberately keeps its last value.
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= alu_sel;
            if (is_shift && (shamt != '0)) begin
              shreg_q <= a;
              cnt_q   <= shamt;
              state_q <= S_SHIFT;
            end else begin
              result_q    <= result_d;
              zf_q        <= zf_d;
              cf_q        <= cf_d;
              vf_q        <= vf_d;
              sf_q        <= sf_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - SHW'(1);
          // Last step: publish the final shifted value directly.
          if (cnt_q == SHW'(1)) begin
            result_q    <= shreg_d;
            zf_q        <= (shreg_d == '0);
            cf_q        <= 1'b0;
            vf_q        <= 1'b0;
            sf_q        <= shreg_d[WIDTH-1];
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign vf        = vf_q;
  assign sf        = sf_q;

endmodule
`default_nettype wire
